// File: rtl/seq_shift_add_mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
// FSM state encodings and the iteration-counter width helper.
package seq_shift_add_mul_pkg;

    // Controller states; the encodings are fixed so debug dumps stay stable.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Counter width able to hold 0..n (the count reaches n on the last step).
    function automatic int cw_for(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/n_bit_pipo.sv
// Parallel-in parallel-out register with asynchronous clear and load enable.
// Used for the A/B operand registers and for the 2N-bit product register.
module n_bit_pipo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Capture d on a load edge; clear wins over everything.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/seq_mul_datapath.sv
// Datapath of the sequential multiplier: operand snapshots, the single N-bit
// adder and the combined {carry, acc, multiplier} right shifter.
// Optional macro SEQ_MUL_SIGNED_EN adds magnitude capture at snapshot time
// and a final two's-complement negate of the result.
module seq_mul_datapath
    import seq_shift_add_mul_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           snap,         // capture operands, clear accumulator
    input  logic           step,         // perform one add/shift iteration
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           signed_mode,
    output logic [2*N-1:0] result
);

    // The low half of the running product shares a register with the
    // multiplier: each shift drops one consumed multiplier bit and brings in
    // one finished product bit, so {acc_hi, mplier} is the full product.
    logic [N-1:0] mcand;
    logic [N-1:0] acc_hi;
    logic [N-1:0] mplier;
    logic [N:0]   sum;
    logic [N-1:0] a_mag;
    logic [N-1:0] b_mag;

`ifdef SEQ_MUL_SIGNED_EN
    logic           neg;
    logic           neg_next;
    logic [2*N-1:0] raw;

    // Magnitudes fit in N unsigned bits, including the most negative value.
    always_comb begin
        a_mag    = (signed_mode && a[N-1]) ? -a : a;
        b_mag    = (signed_mode && b[N-1]) ? -b : b;
        neg_next = signed_mode && (a[N-1] ^ b[N-1]);
    end

    // Result sign is decided at launch and held for the whole operation.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            neg <= 1'b0;
        end else if (snap) begin
            neg <= neg_next;
        end
    end

    assign raw    = {acc_hi, mplier};
    assign result = neg ? -raw : raw;
`else
    logic unused_signed_mode;

    assign a_mag              = a;
    assign b_mag              = b;
    assign result             = {acc_hi, mplier};
    assign unused_signed_mode = signed_mode;
`endif

    // One adder: add the multiplicand into the upper half when the current
    // multiplier bit is set, keeping the carry as bit N.
    always_comb begin
        sum = {1'b0, acc_hi} + (mplier[0] ? {1'b0, mcand} : {(N+1){1'b0}});
    end

    // Snapshot on launch, otherwise shift {carry, acc, multiplier} right by one.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            mcand  <= '0;
            acc_hi <= '0;
            mplier <= '0;
        end else if (snap) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            acc_hi <= '0;
        end else if (step) begin
            acc_hi <= sum[N:1];
            mplier <= {sum[0], mplier[N-1:1]};
        end
    end

endmodule

// File: rtl/seq_shift_add_mul.sv
// Iterative shift-add multiplier, N-bit x N-bit -> 2N-bit, one add per cycle.
// Optional macro SEQ_MUL_SIGNED_EN enables two's-complement operation when
// signed_mode is high at launch; without it every multiply is unsigned.
//
// Handshake: start is sampled only in IDLE. An accepted start raises busy on
// the next cycle; busy stays high for N+1 cycles, then done pulses for exactly
// one cycle together with the new product, which is held until the next done.
// start is accepted again in the done cycle; any start seen while busy is
// dropped, never queued.
module seq_shift_add_mul
    import seq_shift_add_mul_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           clr,
    input  logic [N-1:0]   data_in,
    input  logic           load_a,
    input  logic           load_b,
    input  logic           start,
    input  logic           signed_mode,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product,
    output state_t         state_dbg
);

    localparam int             CW   = cw_for(N);
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   a_q;
    logic [N-1:0]   b_q;
    logic [2*N-1:0] result;
    logic           snap;
    logic           step;
    logic           fin;

    // Operand registers can be reloaded at any time; the datapath works on
    // its own snapshot so an in-flight multiply is unaffected.
    n_bit_pipo #(.W(N)) u_reg_a (
        .clk  (clk),
        .clr  (clr),
        .load (load_a),
        .d    (data_in),
        .q    (a_q)
    );

    n_bit_pipo #(.W(N)) u_reg_b (
        .clk  (clk),
        .clr  (clr),
        .load (load_b),
        .d    (data_in),
        .q    (b_q)
    );

    assign snap = (state == ST_IDLE) && start;
    assign step = (state == ST_RUN);
    assign fin  = (state == ST_FIN);

    seq_mul_datapath #(.N(N)) u_datapath (
        .clk         (clk),
        .clr         (clr),
        .snap        (snap),
        .step        (step),
        .a           (a_q),
        .b           (b_q),
        .signed_mode (signed_mode),
        .result      (result)
    );

    // Product is written only in FIN, so it changes exactly when done rises.
    n_bit_pipo #(.W(2*N)) u_reg_p (
        .clk  (clk),
        .clr  (clr),
        .load (fin),
        .d    (result),
        .q    (product)
    );

    // Controller: IDLE waits for start, RUN does N iterations, FIN publishes.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= ST_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_seq_shift_add_mul.sv
// Bench for seq_shift_add_mul (N=8): directed vectors plus a cycle-level
// reference model compared against busy/done/product on every falling edge.
module tb_seq_shift_add_mul;
    import seq_shift_add_mul_pkg::*;

    localparam int N  = 8;
    localparam int W2 = 2 * N;

    // ---------------- clock / reset / DUT ----------------
    logic          clk         = 1'b0;
    logic          clr         = 1'b1;
    logic [N-1:0]  data_in     = '0;
    logic          load_a      = 1'b0;
    logic          load_b      = 1'b0;
    logic          start       = 1'b0;
    logic          signed_mode = 1'b0;
    logic          busy;
    logic          done;
    logic [W2-1:0] product;
    state_t        state_dbg;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    seq_shift_add_mul #(.N(N)) u_dut (
        .clk         (clk),
        .clr         (clr),
        .data_in     (data_in),
        .load_a      (load_a),
        .load_b      (load_b),
        .start       (start),
        .signed_mode (signed_mode),
        .busy        (busy),
        .done        (done),
        .product     (product),
        .state_dbg   (state_dbg)
    );

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [W2-1:0] expected_product(input logic [N-1:0] a,
                                                       input logic [N-1:0] b,
                                                       input logic sm);
`ifdef SEQ_MUL_SIGNED_EN
        if (sm) begin
            logic signed [W2-1:0] sa;
            logic signed [W2-1:0] sb;
            sa = {{N{a[N-1]}}, a};
            sb = {{N{b[N-1]}}, b};
            return sa * sb;
        end
`else
        begin
            logic unused_sm;
            unused_sm = sm;
        end
`endif
        return {{N{1'b0}}, a} * {{N{1'b0}}, b};
    endfunction

    logic [N-1:0]  m_a       = '0;
    logic [N-1:0]  m_b       = '0;
    logic [W2-1:0] m_product = '0;
    logic [W2-1:0] m_pending = '0;
    logic          m_busy    = 1'b0;
    logic          m_done    = 1'b0;
    int            m_left    = 0;

    // An accepted start keeps the unit occupied for N+1 edges; the last of
    // those publishes the product. Starts during that window are dropped.
    always @(posedge clk or posedge clr) begin
        if (clr) begin
            m_a       <= '0;
            m_b       <= '0;
            m_product <= '0;
            m_pending <= '0;
            m_busy    <= 1'b0;
            m_done    <= 1'b0;
            m_left    <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_product <= m_pending;
                    m_done    <= 1'b1;
                    m_busy    <= 1'b0;
                end
            end else if (start) begin
                m_pending <= expected_product(m_a, m_b, signed_mode);
                m_left    <= N + 1;
                m_busy    <= 1'b1;
            end
            if (load_a) m_a <= data_in;
            if (load_b) m_b <= data_in;
        end
    end

    // Per-cycle compare of all handshake/result outputs against the model.
    always @(negedge clk) begin
        check("cycle {busy,done,product}",
              32'({busy, done, product}), 32'({m_busy, m_done, m_product}));
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ops(input logic [N-1:0] a, input logic [N-1:0] b);
        data_in = a;
        load_a  = 1'b1;
        tick();
        load_a  = 1'b0;
        data_in = b;
        load_b  = 1'b1;
        tick();
        load_b  = 1'b0;
    endtask

    task automatic pulse_start(input logic sm, output int t0);
        start       = 1'b1;
        signed_mode = sm;
        tick();
        start       = 1'b0;
        signed_mode = 1'b0;
        t0          = cyc;
    endtask

    // Bounded wait for done; reports cycles since the start edge and how many
    // samples saw busy high before done.
    task automatic wait_done(input int t0, output int lat, output int busy_n, output int seen);
        busy_n = 0;
        seen   = 0;
        for (int k = 0; k < 4 * N; k++) begin
            if (busy) busy_n++;
            if (done) begin
                seen = 1;
                break;
            end
            tick();
        end
        lat = cyc - t0;
    endtask

    task automatic run_mul(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic sm, input logic [W2-1:0] exp);
        int t0, lat, bn, seen;
        load_ops(a, b);
        pulse_start(sm, t0);
        wait_done(t0, lat, bn, seen);
        check({name, " done seen"}, 32'(seen), 32'd1);
        check({name, " latency"}, 32'(lat), 32'(N + 1));
        check({name, " product"}, 32'(product), 32'(exp));
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            tick();
            if (done) n++;
        end
    endtask

    // ---------------- directed stimulus ----------------
    typedef struct {
        logic [N-1:0]  a;
        logic [N-1:0]  b;
        logic          sm;
        logic [W2-1:0] exp;
    } vec_t;

    initial begin
        int   t0, t1, lat, bn, seen, nd;
        vec_t vecs[8];

        vecs[0] = '{8'h80, 8'h80, 1'b1, 16'h4000};
`ifdef SEQ_MUL_SIGNED_EN
        vecs[1] = '{8'hFD, 8'h05, 1'b1, 16'hFFF1};
        vecs[2] = '{8'h7F, 8'h81, 1'b1, 16'hC0FF};
`else
        vecs[1] = '{8'hFD, 8'h05, 1'b1, 16'h04F1};
        vecs[2] = '{8'h7F, 8'h81, 1'b1, 16'h3FFF};
`endif
        vecs[3] = '{8'hFD, 8'h05, 1'b0, 16'h04F1};
        vecs[4] = '{8'h01, 8'h01, 1'b0, 16'h0001};
        vecs[5] = '{8'h80, 8'h02, 1'b0, 16'h0100};
        vecs[6] = '{8'hFF, 8'h01, 1'b0, 16'h00FF};
        vecs[7] = '{8'hA5, 8'h5A, 1'b0, 16'h3A02};

        // Reset state
        clr = 1'b1;
        tick();
        tick();
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset product", 32'(product), 32'd0);
        check("reset state", 32'(state_dbg), 32'(ST_IDLE));
        clr = 1'b0;
        tick();

        // Largest unsigned operands: busy for N+1 cycles, done N+1 after start
        load_ops(8'hFF, 8'hFF);
        pulse_start(1'b0, t0);
        wait_done(t0, lat, bn, seen);
        check("FFxFF done seen", 32'(seen), 32'd1);
        check("FFxFF latency", 32'(lat), 32'(N + 1));
        check("FFxFF busy cycles", 32'(bn), 32'(N + 1));
        check("FFxFF product", 32'(product), 32'h0000FE01);

        // Zero operand, then back-to-back start in the done cycle
        load_ops(8'h00, 8'hB7);
        pulse_start(1'b0, t0);
        load_ops(8'h0C, 8'h0D);
        wait_done(t0, lat, bn, seen);
        check("00xB7 done seen", 32'(seen), 32'd1);
        check("00xB7 latency", 32'(lat), 32'(N + 1));
        check("00xB7 product", 32'(product), 32'h00000000);
        pulse_start(1'b0, t1);
        check("back-to-back spacing", 32'(t1 - t0), 32'(N + 2));
        wait_done(t1, lat, bn, seen);
        check("0Cx0D done seen", 32'(seen), 32'd1);
        check("0Cx0D latency", 32'(lat), 32'(N + 1));
        check("0Cx0D product", 32'(product), 32'h0000009C);

        // start and reload of A while running are both ignored by the operation
        load_ops(8'h10, 8'h03);
        pulse_start(1'b0, t0);
        tick();
        tick();
        data_in = 8'h55;
        load_a  = 1'b1;
        start   = 1'b1;
        tick();
        load_a  = 1'b0;
        start   = 1'b0;
        wait_done(t0, lat, bn, seen);
        check("10x03 done seen", 32'(seen), 32'd1);
        check("10x03 latency", 32'(lat), 32'(N + 1));
        check("10x03 product", 32'(product), 32'h00000030);
        count_dones(2 * N, nd);
        check("10x03 single done", 32'(nd), 32'd0);
        pulse_start(1'b0, t0);
        wait_done(t0, lat, bn, seen);
        check("reloaded A x03 product", 32'(product), 32'h000000FF);

        // clr mid-operation aborts without a done pulse
        load_ops(8'h7F, 8'h7F);
        pulse_start(1'b0, t0);
        tick();
        tick();
        tick();
        clr = 1'b1;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort product", 32'(product), 32'd0);
        tick();
        clr = 1'b0;
        count_dones(2 * N, nd);
        check("abort no done", 32'(nd), 32'd0);
        run_mul("02x03", 8'h02, 8'h03, 1'b0, 16'h0006);

        // Signed-mode and extra unsigned vectors
        foreach (vecs[i]) begin
            run_mul($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].exp);
        end

        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Watchdog against a hung run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
